// File: rtl/csc_addr_spad_pingpong_if.sv
// Bus bundle for the double-buffered CSC address scratchpad: decoder write
// handshake on one side, PE read controls and status on the other.
interface csc_addr_spad_pingpong_if #(
   parameter int ADDR_W = 7,
   parameter int DEPTH  = 32
);
   localparam int IDX_W = $clog2(DEPTH);

   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_data;
   logic              write_en;
   logic              write_fin;
   logic [ADDR_W-1:0] rd_data;
   logic              rd_valid;
   logic [IDX_W-1:0]  read_idx;
   logic              read_idx_en;
   logic              addr_read_inc;
   logic              read_fin;
   logic              wr_bank;
   logic              rd_bank;
   logic              overflow_err;

   // Producer/consumer side: drives beats and read controls
   modport master (
      output in_valid, in_data, write_en, read_idx, read_idx_en, addr_read_inc,
      input  in_ready, write_fin, rd_data, rd_valid, read_fin, wr_bank, rd_bank,
             overflow_err
   );

   // Scratchpad side
   modport slave (
      input  in_valid, in_data, write_en, read_idx, read_idx_en, addr_read_inc,
      output in_ready, write_fin, rd_data, rd_valid, read_fin, wr_bank, rd_bank,
             overflow_err
   );
endinterface

// File: rtl/csc_addr_spad_pingpong.sv
// Double-buffered CSC address scratchpad. The decoder fills one bank with a
// zero-terminated address vector while the PE walks the other bank; a bank
// changes hands only when its vector is complete (write side) or fully
// consumed (read side). Over-long vectors are force-terminated and flagged.
module csc_addr_spad_pingpong #(
   parameter int ADDR_W   = 7,
   parameter int DEPTH    = 32,
   parameter int END_CODE = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   csc_addr_spad_pingpong_if.slave bus
);
   localparam int                IDX_W    = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] END_VAL  = ADDR_W'(END_CODE);
   localparam logic [ADDR_W-1:0] FILL_VAL = '1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

   logic [ADDR_W-1:0] r_mem [2][DEPTH];
   logic [IDX_W-1:0]  r_wr_ptr;
   logic [IDX_W-1:0]  r_rd_ptr;
   logic              r_wr_bank;
   logic              r_rd_bank;
   logic [1:0]        r_full;
   logic              r_overflow;

   logic              w_in_ready;
   logic              w_shake;
   logic              w_is_end;
   logic              w_wr_last;
   logic              w_write_fin;
   logic              w_overflow;
   logic [ADDR_W-1:0] w_wr_data;
   logic              w_rd_valid;
   logic [ADDR_W-1:0] w_rd_data;
   logic              w_read_fin;

   // Write side: a bank accepts beats until it is closed by a terminator
   // or by running out of entries, in which case the terminator is forced.
   assign w_in_ready  = ~r_full[r_wr_bank];
   assign w_shake     = bus.in_valid & w_in_ready & bus.write_en;
   assign w_is_end    = (bus.in_data == END_VAL);
   assign w_wr_last   = (r_wr_ptr == LAST_IDX);
   assign w_write_fin = w_shake & (w_is_end | w_wr_last);
   assign w_overflow  = w_shake & ~w_is_end & w_wr_last;
   assign w_wr_data   = w_write_fin ? END_VAL : bus.in_data;

   // Read side: the bank is released when the PE steps past the terminator;
   // a random-access load in the same cycle wins over the step.
   assign w_rd_valid  = r_full[r_rd_bank];
   assign w_rd_data   = r_mem[r_rd_bank][r_rd_ptr];
   assign w_read_fin  = w_rd_valid & bus.addr_read_inc & ~bus.read_idx_en &
                        (w_rd_data == END_VAL);

   assign bus.in_ready     = w_in_ready;
   assign bus.write_fin    = w_write_fin;
   assign bus.rd_data      = w_rd_data;
   assign bus.rd_valid     = w_rd_valid;
   assign bus.read_fin     = w_read_fin;
   assign bus.wr_bank      = r_wr_bank;
   assign bus.rd_bank      = r_rd_bank;
   assign bus.overflow_err = r_overflow;

   // Address storage: accepted beats land at the write pointer of the write bank
   always_ff @(posedge clock) begin
      // NOTE: the array is reset like any other register because a freshly
      // reset spad must read back all-ones, not stale addresses.
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int e = 0; e < DEPTH; e++) begin
               r_mem[b][e] <= FILL_VAL;
            end
         end
      end else if (w_shake) begin
         r_mem[r_wr_bank][r_wr_ptr] <= w_wr_data;
      end
   end

   // Pointer, bank-ownership and status bookkeeping for both sides
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments here let write_fin and read_fin update
      // different bits of r_full in the same cycle without ordering hazards.
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_wr_bank  <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_full     <= 2'b00;
         r_overflow <= 1'b0;
      end else begin
         if (w_write_fin) begin
            r_full[r_wr_bank] <= 1'b1;
            r_wr_bank         <= ~r_wr_bank;
            r_wr_ptr          <= '0;
         end else if (w_shake) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end

         if (w_overflow) begin
            r_overflow <= 1'b1;
         end

         if (w_read_fin) begin
            r_full[r_rd_bank] <= 1'b0;
            r_rd_bank         <= ~r_rd_bank;
            r_rd_ptr          <= '0;
         end else if (w_rd_valid && bus.read_idx_en) begin
            r_rd_ptr <= bus.read_idx;
         end else if (w_rd_valid && bus.addr_read_inc) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_csc_addr_spad_pingpong.sv
// Bench for the double-buffered CSC address scratchpad. The reference model
// treats the spad as a FIFO of completed vectors (at most two) plus the
// vector currently being assembled; bank numbers are the parity of how many
// vectors have been completed / consumed.
module tb_csc_addr_spad_pingpong;
   localparam int ADDR_W = 7;
   localparam int DEPTH  = 32;

   logic clock;
   logic reset;

   csc_addr_spad_pingpong_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

   csc_addr_spad_pingpong #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .END_CODE (0)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference model state
   logic [6:0] fifo_q [$];   // entries of all completed vectors, oldest first
   int         len_q  [$];   // length of each completed vector
   logic [6:0] wbuf   [$];   // vector being assembled
   int         m_idx;        // read position inside the oldest vector
   int         m_nwr;        // vectors completed so far
   int         m_nrd;        // vectors consumed so far
   logic       m_ovf;

   int n_vec;
   int n_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      fifo_q.delete();
      len_q.delete();
      wbuf.delete();
      m_idx = 0;
      m_nwr = 0;
      m_nrd = 0;
      m_ovf = 1'b0;
   endtask

   task automatic drive(input logic iv, input logic we, input logic [6:0] d,
                        input logic inc, input logic ien, input logic [4:0] idx);
      bus.in_valid      = iv;
      bus.write_en      = we;
      bus.in_data       = d;
      bus.addr_read_inc = inc;
      bus.read_idx_en   = ien;
      bus.read_idx      = idx;
   endtask

   // One clock: compare every output against the model, then advance the model.
   task automatic cycle();
      logic       iv, we, ien, inc, ready_e, valid_e, shake, term, rfin_e;
      logic [6:0] din, head;
      logic [4:0] ridx;
      @(negedge clock);
      iv   = bus.in_valid;
      we   = bus.write_en;
      din  = bus.in_data;
      inc  = bus.addr_read_inc;
      ien  = bus.read_idx_en;
      ridx = bus.read_idx;
      ready_e = (len_q.size() < 2);
      valid_e = (len_q.size() > 0);
      head    = 7'h7f;
      if (valid_e) head = fifo_q[m_idx];
      shake  = iv & we & ready_e;
      term   = shake & ((din == 7'd0) || (wbuf.size() == DEPTH - 1));
      rfin_e = valid_e & inc & ~ien & (head == 7'd0);
      check("in_ready",     bus.in_ready,     ready_e);
      check("write_fin",    bus.write_fin,    term);
      check("rd_valid",     bus.rd_valid,     valid_e);
      check("read_fin",     bus.read_fin,     rfin_e);
      check("wr_bank",      bus.wr_bank,      m_nwr % 2);
      check("rd_bank",      bus.rd_bank,      m_nrd % 2);
      check("overflow_err", bus.overflow_err, m_ovf);
      if (valid_e) check("rd_data", bus.rd_data, head);
      @(posedge clock);
      if (valid_e) begin
         if (ien) begin
            m_idx = int'(ridx);
         end else if (rfin_e) begin
            for (int k = 0; k < len_q[0]; k++) void'(fifo_q.pop_front());
            void'(len_q.pop_front());
            m_idx = 0;
            m_nrd++;
         end else if (inc) begin
            m_idx++;
         end
      end
      if (shake) begin
         if (term) begin
            if (din != 7'd0) m_ovf = 1'b1;
            wbuf.push_back(7'd0);
            foreach (wbuf[k]) fifo_q.push_back(wbuf[k]);
            len_q.push_back(wbuf.size());
            wbuf.delete();
            m_nwr++;
         end else begin
            wbuf.push_back(din);
         end
      end
      #1;
   endtask

   task automatic wr(input logic [6:0] d);
      drive(1'b1, 1'b1, d, 1'b0, 1'b0, 5'd0);
      cycle();
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 5'd0);
      cycle();
   endtask

   // Consume every stored vector with plain increments, bounded in cycles.
   task automatic drain();
      int budget;
      budget = 200;
      drive(1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 5'd0);
      while (len_q.size() > 0 && budget > 0) begin
         cycle();
         budget--;
      end
      check("drain_done", bus.rd_valid, 1'b0);
      idle();
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(posedge clock);
      #1;
      reset = 1'b0;
      model_clear();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      drive(1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 5'd0);
      do_reset(2);

      // Reset state
      check("rst_in_ready",  bus.in_ready,     1'b1);
      check("rst_rd_valid",  bus.rd_valid,     1'b0);
      check("rst_write_fin", bus.write_fin,    1'b0);
      check("rst_read_fin",  bus.read_fin,     1'b0);
      check("rst_rd_data",   bus.rd_data,      7'd127);
      check("rst_overflow",  bus.overflow_err, 1'b0);
      check("rst_banks",     {bus.wr_bank, bus.rd_bank}, 2'b00);

      // Single vector 5,9,0 written then read back
      wr(7'd5);
      wr(7'd9);
      wr(7'd0);
      check("t1_rd_valid", bus.rd_valid, 1'b1);
      check("t1_rd_bank",  bus.rd_bank,  1'b0);
      check("t1_rd_data",  bus.rd_data,  7'd5);
      drive(1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 5'd0);
      repeat (3) cycle();
      check("t1_rd_bank_after", bus.rd_bank, 1'b1);
      idle();

      // Ping-pong: stream the next vector while the previous one is read
      wr(7'd3);
      wr(7'd0);
      drive(1'b1, 1'b1, 7'd7, 1'b1, 1'b0, 5'd0);
      cycle();
      check("t2_no_stall", bus.in_ready, 1'b1);
      drive(1'b1, 1'b1, 7'd8, 1'b1, 1'b0, 5'd0);
      cycle();
      drive(1'b1, 1'b1, 7'd0, 1'b0, 1'b0, 5'd0);
      cycle();
      check("t2_rd_data", bus.rd_data, 7'd7);
      drain();

      // Both banks full: third vector stalls until a bank is released
      wr(7'd1);
      wr(7'd0);
      wr(7'd2);
      wr(7'd2);
      wr(7'd0);
      drive(1'b1, 1'b1, 7'd4, 1'b0, 1'b0, 5'd0);
      repeat (3) cycle();
      check("t3_stall", bus.in_ready, 1'b0);
      drive(1'b1, 1'b1, 7'd4, 1'b1, 1'b0, 5'd0);
      repeat (2) cycle();
      check("t3_released", bus.in_ready, 1'b1);
      wr(7'd4);
      wr(7'd0);
      drain();

      // Overflow: DEPTH non-terminator beats force a terminator into the last entry
      for (int i = 0; i < DEPTH; i++) wr(7'(i + 1));
      idle();
      check("t4_overflow", bus.overflow_err, 1'b1);
      drive(1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 5'd31);
      cycle();
      check("t4_last_entry", bus.rd_data, 7'd0);
      drain();

      // Random-access load beats a same-cycle increment
      wr(7'd1);
      wr(7'd4);
      wr(7'd6);
      wr(7'd0);
      drive(1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 5'd2);
      cycle();
      check("t5_idx_load", bus.rd_data, 7'd6);
      drive(1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 5'd0);
      cycle();
      check("t5_after_inc", bus.rd_data, 7'd0);
      cycle();
      check("t5_ovf_sticky", bus.overflow_err, 1'b1);
      idle();

      // Randomised traffic on both sides
      for (int c = 0; c < 1500; c++) begin
         bus.in_valid      = ($urandom_range(3) != 0);
         bus.write_en      = ($urandom_range(7) != 0);
         bus.in_data       = ($urandom_range(4) == 0) ? 7'd0 : 7'($urandom_range(127, 1));
         bus.addr_read_inc = ($urandom_range(1) != 0);
         bus.read_idx_en   = ($urandom_range(7) == 0);
         if (len_q.size() > 0) bus.read_idx = 5'($urandom_range(len_q[0] - 1));
         else                  bus.read_idx = 5'($urandom);
         cycle();
      end
      drive(1'b1, 1'b1, 7'd0, 1'b0, 1'b0, 5'd0);
      cycle();
      drain();

      // Reset in the middle of a read and a partial write
      wr(7'd2);
      wr(7'd3);
      wr(7'd0);
      drive(1'b1, 1'b1, 7'd9, 1'b1, 1'b0, 5'd0);
      cycle();
      drive(1'b1, 1'b1, 7'd9, 1'b0, 1'b0, 5'd0);
      repeat (2) cycle();
      do_reset(1);
      drive(1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 5'd0);
      #1;
      check("rst2_rd_valid", bus.rd_valid,     1'b0);
      check("rst2_rd_data",  bus.rd_data,      7'd127);
      check("rst2_overflow", bus.overflow_err, 1'b0);
      check("rst2_in_ready", bus.in_ready,     1'b1);
      check("rst2_banks",    {bus.wr_bank, bus.rd_bank}, 2'b00);
      wr(7'd5);
      wr(7'd0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
